if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- IF stage of the rv32i pipeline.
- Owns the fetch PC and runs the instruction-memory read handshake.
- Delivers {pc_out, instruction} with a valid flag into the IF/ID register, where it populates the pc_out and instruction fields of rv32i_data_packet_t.
- Accepts stall from the hazard unit and redirect (taken branch or jump) from EX. Squashes wrong-path fetches, including a request still outstanding when the redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0060, PC of the first fetch after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- if_stall  in  1  downstream cannot accept this cycle.
- redirect_valid  in  1  one-cycle pulse from EX: flush and refetch.
- redirect_pc  in  32  redirect target.
- inst_mem_rdata  in  32  instruction data, valid with inst_mem_resp.
- inst_mem_resp  in  1  one-cycle read-completion pulse.
- inst_mem_read  out  1  read request.
- inst_mem_address  out  32  read address.
- if_valid  out  1  if_pc/if_instruction are valid.
- if_pc  out  32  PC of the delivered instruction.
- if_instruction  out  32  delivered instruction.

Behaviour:
- Internal registers:
  - pc: next fetch address.
  - req_addr: address of the outstanding request.
  - state in {REQ, HOLD, DISCARD}.
  - Output register {if_valid, if_pc, if_instruction}.
- Reset (rst==0 at a clk edge):
  - pc=RESET_PC, req_addr=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_instruction=0.
  - First cycle after reset: inst_mem_read=1, address=RESET_PC.
  - Reset asserted mid-request abandons the request; a late resp arriving in REQ after reset is treated as the RESET_PC response. The memory side is reset together with this block.
- Memory protocol:
  - inst_mem_read and inst_mem_address are combinational from state/req_addr.
  - inst_mem_read=1 in REQ and DISCARD, 0 in HOLD.
  - Address equals req_addr and stays stable while read is high, until resp.
  - Resp arrives no earlier than 1 cycle after read is asserted.
- REQ:
  - req_addr==pc.
  - resp, no redirect: capture if_pc=req_addr, if_instruction=inst_mem_rdata, if_valid=1; pc=pc+4 (mod 2^32, wrap allowed); next state HOLD.
  - resp with redirect same cycle: drop data; pc=req_addr=redirect_pc; stay REQ. A new request is issued the next cycle.
  - redirect, no resp: pc=redirect_pc, keep req_addr; next state DISCARD.
- HOLD:
  - if_valid=1 and outputs stable while if_stall=1.
  - !if_stall (consumed): if_valid=0 next cycle, req_addr=pc, next state REQ.
- DISCARD:
  - Read held at the old req_addr.
  - resp: data dropped, req_addr=pc, next state REQ.
  - A further redirect updates pc, so the last redirect wins; it may coincide with resp.
- Flush: redirect_valid clears if_valid on the next cycle in every state. Redirect beats if_stall.
- redirect_pc[1:0] is forced to 2'b00 when loaded.
- The output register never changes while if_valid=1 && if_stall=1 && !redirect_valid.
- Throughput: one instruction per (memory latency + 2) cycles minimum.

Decomposition:
- Add fetch_state_t enum {REQ, HOLD, DISCARD} to the rv32i_types package. Add RESET_PC default as a constant there, shared with top-level PC reuse.
- No sub-module; single always_ff plus a next-state always_comb.

Test Plan:
1. Reset release, memory resp 1 cycle after each read, no stall → address sequence 0x60, 0x64, 0x68; if_pc 0x60/0x64/0x68 with if_instruction equal to the returned data; if_valid high every 3rd cycle.
2. if_stall=1 for 5 cycles while in HOLD with if_pc=0x64 → outputs frozen, inst_mem_read=0. Stall drop → read of 0x68 the next cycle.
3. redirect_valid with redirect_pc=0x200 while the read of 0x68 is outstanding, resp 3 cycles later → address held at 0x68 until resp, data dropped, next read 0x200, first valid if_pc=0x200.
4. redirect (0x300) in the same cycle as resp for 0x6C → 0x6C never valid, next read 0x300. Also a second redirect (0x400) during DISCARD → next read 0x400.
5. Redirect during HOLD with if_stall=1 → if_valid=0 next cycle, read of redirect_pc issued. Also redirect_pc=0x203 → fetch of 0x200.
6. rst=0 asserted in HOLD and in DISCARD → next cycle if_valid=0, read=1 at address 0x60. Also pc=0xFFFF_FFFC fetch → next pc 0x0000_0000.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared rv32i pipeline types and constants
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: rv32i IF stage, owns the fetch PC and the instruction-memory read handshake
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst_mem_rdata,
    input  logic        inst_mem_resp,
    output logic        inst_mem_read,
    output logic [31:0] inst_mem_address,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, req_addr_q, req_addr_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d, if_instruction_q, if_instruction_d;
    logic [31:0]  redirect_target;

    assign redirect_target  = {redirect_pc[31:2], 2'b00};
    assign inst_mem_read    = (state_q != HOLD);
    assign inst_mem_address = req_addr_q;
    assign if_valid         = if_valid_q;
    assign if_pc            = if_pc_q;
    assign if_instruction   = if_instruction_q;

    // Next-state: fetch sequencing, squashing of wrong-path responses, output capture
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        req_addr_d       = req_addr_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_instruction_d = if_instruction_q;
        case (state_q)
            REQ: begin
                if (inst_mem_resp && redirect_valid) begin
                    pc_d       = redirect_target;
                    req_addr_d = redirect_target;
                end else if (inst_mem_resp) begin
                    if_valid_d       = 1'b1;
                    if_pc_d          = req_addr_q;
                    if_instruction_d = inst_mem_rdata;
                    pc_d             = pc_q + 32'd4;
                    state_d          = HOLD;
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    req_addr_d = redirect_target;
                    state_d    = REQ;
                end else if (!if_stall) begin
                    if_valid_d = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end
            DISCARD: begin
                // The outstanding read stays on the bus; the newest redirect target wins
                if (redirect_valid) pc_d = redirect_target;
                if (inst_mem_resp) begin
                    req_addr_d = pc_d;
                    state_d    = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (redirect_valid) if_valid_d = 1'b0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= REQ;
            pc_q             <= RESET_PC;
            req_addr_q       <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= 32'd0;
            if_instruction_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            req_addr_q       <= req_addr_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_instruction_q <= if_instruction_d;
        end
    end

endmodule
